// File: rtl/key_debounce_repeat.sv
// Push-button conditioner: per-key 2-flop synchroniser, debounce FSM and auto-repeat tic.
// Inputs are active-low raw buttons; every output is a registered active-high level or pulse.
module key_debounce_repeat #(
  parameter int unsigned          N_KEYS          = 4,
  parameter int unsigned          DEBOUNCE_CYCLES = 240000,
  parameter int unsigned          REPEAT_DELAY    = 6000000,
  parameter int unsigned          REPEAT_PERIOD   = 1200000,
  parameter logic [N_KEYS-1:0]    REPEAT_EN       = {N_KEYS{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_state,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_tic
);

  localparam int unsigned MaxDbRd   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                                      DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MaxCycles = (MaxDbRd > REPEAT_PERIOD) ? MaxDbRd : REPEAT_PERIOD;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] DebLast    = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] DelayLast  = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] PeriodLast = CntW'(REPEAT_PERIOD - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  typedef enum logic [2:0] {
    StReleased,
    StPressWait,
    StHeld,
    StRepeating,
    StReleaseWait
  } state_e;

  // Synchroniser resets to the released (high) level so no false press follows reset.
  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] sync1_d, sync2_d;
  logic [N_KEYS-1:0] raw_p;

  always_comb begin
    sync1_d = i_key;
    sync2_d = sync1_q;
    raw_p   = ~sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    state_e          st_q, st_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            tic_q, tic_d;

    always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      tic_d     = 1'b0;

      unique case (st_q)
        StReleased: begin
          if (raw_p[k]) begin
            st_d  = StPressWait;
            cnt_d = '0;
          end
        end
        StPressWait: begin
          if (!raw_p[k]) begin
            st_d  = StReleased;
            cnt_d = '0;
          end else if (cnt_q == DebLast) begin
            st_d    = StHeld;
            cnt_d   = '0;
            press_d = 1'b1;
            tic_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StHeld: begin
          if (!raw_p[k]) begin
            st_d  = StReleaseWait;
            cnt_d = '0;
          end else if (cnt_q == DelayLast) begin
            // With repeat disabled the counter parks here instead of wrapping.
            if (REPEAT_EN[k]) begin
              st_d  = StRepeating;
              cnt_d = '0;
              tic_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StRepeating: begin
          if (!raw_p[k]) begin
            st_d  = StReleaseWait;
            cnt_d = '0;
          end else if (cnt_q == PeriodLast) begin
            cnt_d = '0;
            tic_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StReleaseWait: begin
          if (raw_p[k]) begin
            st_d  = StHeld;
            cnt_d = '0;
          end else if (cnt_q == DebLast) begin
            st_d      = StReleased;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          st_d  = StReleased;
          cnt_d = '0;
        end
      endcase

      level_d = (st_d == StHeld) || (st_d == StRepeating) || (st_d == StReleaseWait);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q      <= StReleased;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        tic_q     <= 1'b0;
      end else begin
        st_q      <= st_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        tic_q     <= tic_d;
      end
    end

    assign o_state[k]   = level_q;
    assign o_press[k]   = press_q;
    assign o_release[k] = release_q;
    assign o_tic[k]     = tic_q;
  end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Directed bench for key_debounce_repeat with short debounce/repeat timings.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_key_debounce_repeat;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] i_key;
  logic [3:0] o_state, o_press, o_release, o_tic;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  key_debounce_repeat #(
    .N_KEYS          (4),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8),
    .REPEAT_EN       (4'b1011)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_key     (i_key),
    .o_state   (o_state),
    .o_press   (o_press),
    .o_release (o_release),
    .o_tic     (o_tic)
  );

  task automatic chk(input string tag, input int e, input logic [3:0] obs,
                     input logic [3:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s edge %0d: observed %b expected %b", tag, e, obs, want);
    end
  endtask

  task automatic chk_all(input string tag, input int e, input logic [3:0] st,
                         input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] tc);
    chk({tag, ".state"}, e, o_state, st);
    chk({tag, ".press"}, e, o_press, pr);
    chk({tag, ".release"}, e, o_release, rl);
    chk({tag, ".tic"}, e, o_tic, tc);
  endtask

  // Key k low for edges 0..hold-1; press at edge 6, release at hold+6, tics where tic_at set.
  task automatic press_hold(input string tag, input int k, input int hold, input int cycles,
                            input logic [127:0] tic_at);
    logic [3:0] st, pr, rl, tc;
    for (int e = 0; e < cycles; e++) begin
      i_key[k] = (e < hold) ? 1'b0 : 1'b1;
      @(negedge clk);
      st = '0; pr = '0; rl = '0; tc = '0;
      st[k] = (e >= 6) && (e < hold + 6);
      pr[k] = (e == 6);
      rl[k] = (e == hold + 6);
      tc[k] = tic_at[e];
      chk_all(tag, e, st, pr, rl, tc);
    end
  endtask

  initial begin
    logic [127:0] tics;
    logic [3:0]   st, pr, rl;

    rst_n = 1'b0;
    i_key = 4'hF;
    @(negedge clk);
    chk_all("reset", 0, 4'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      chk_all("idle", e, 4'h0, 4'h0, 4'h0, 4'h0);
    end

    // Clean press on key0, held 15 cycles: no repeat before release.
    tics = '0;
    tics[6] = 1'b1;
    press_hold("clean0", 0, 15, 30, tics);

    // 3-cycle bounce on key0: rejected.
    for (int e = 0; e < 12; e++) begin
      i_key[0] = (e < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      chk_all("bounce0", e, 4'h0, 4'h0, 4'h0, 4'h0);
    end

    // Held key0 with a 2-cycle high glitch at edges 15,16; repeat delay restarts, no release.
    for (int e = 0; e < 44; e++) begin
      i_key[0] = (e < 30 && e != 15 && e != 16) ? 1'b0 : 1'b1;
      @(negedge clk);
      chk_all("glitch0", e, {3'b000, (e >= 6 && e < 36)}, {3'b000, (e == 6)},
              {3'b000, (e == 36)}, {3'b000, (e == 6)});
    end

    // Key1 held 60 cycles: press tic plus auto-repeat.
    tics = '0;
    tics[6] = 1'b1; tics[26] = 1'b1; tics[34] = 1'b1;
    tics[42] = 1'b1; tics[50] = 1'b1; tics[58] = 1'b1;
    press_hold("repeat1", 1, 60, 72, tics);

    // Key2 has repeat disabled: a single tic only.
    tics = '0;
    tics[6] = 1'b1;
    press_hold("norep2", 2, 60, 72, tics);

    // Keys 0 and 3 pressed one cycle apart, each held 10 cycles.
    for (int e = 0; e < 22; e++) begin
      i_key[0] = (e < 10) ? 1'b0 : 1'b1;
      i_key[3] = (e >= 1 && e < 11) ? 1'b0 : 1'b1;
      @(negedge clk);
      st = {(e >= 7 && e < 17), 2'b00, (e >= 6 && e < 16)};
      pr = {(e == 7), 2'b00, (e == 6)};
      rl = {(e == 17), 2'b00, (e == 16)};
      chk_all("pair03", e, st, pr, rl, pr);
    end

    // Key1 held, then asynchronous reset between edges.
    for (int e = 0; e < 11; e++) begin
      i_key[1] = 1'b0;
      @(negedge clk);
      chk_all("prerst1", e, {2'b00, (e >= 6), 1'b0}, {2'b00, (e == 6), 1'b0}, 4'h0,
              {2'b00, (e == 6), 1'b0});
    end
    #2 rst_n = 1'b0;
    #1 chk_all("rst_async", 0, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int e = 0; e < 2; e++) begin
      @(negedge clk);
      chk_all("rst_hold", e, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    rst_n = 1'b1;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      chk_all("postrst1", e, {2'b00, (e >= 6), 1'b0}, {2'b00, (e == 6), 1'b0}, 4'h0,
              {2'b00, (e == 6), 1'b0});
    end
    for (int e = 0; e < 10; e++) begin
      i_key[1] = 1'b1;
      @(negedge clk);
      chk_all("relrst1", e, {2'b00, (e < 6), 1'b0}, 4'h0, {2'b00, (e == 6), 1'b0}, 4'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
